// File: rtl/serial_out.sv
// serial_out: streams feature records from the record RAM one bit per
// handshake, prefetching the next record so records run back to back.
module serial_out #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_dp,
  input  logic [3:0]            feat,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ser,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   num_dp_q, num_dp_d;
  logic [3:0]              feat_q, feat_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0]   nbuf_q, nbuf_d;
  logic                    nvld_q, nvld_d;
  logic                    cap_q, cap_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   rec_q, rec_d;
  logic                    done_q, done_d;

  logic [CW-1:0]           init;
  logic [ADDR_WIDTH:0]     rec_p2;

  assign init   = CW'(DATA_WIDTH - LENGTH * (int'(feat_q) + 1));
  assign rec_p2 = {1'b0, rec_q} + (ADDR_WIDTH+1)'(2);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      num_dp_q  <= '0;
      feat_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      sreg_q    <= '0;
      nbuf_q    <= '0;
      nvld_q    <= 1'b0;
      cap_q     <= 1'b0;
      cnt_q     <= '0;
      rec_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_dp_q  <= num_dp_d;
      feat_q    <= feat_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      sreg_q    <= sreg_d;
      nbuf_q    <= nbuf_d;
      nvld_q    <= nvld_d;
      cap_q     <= cap_d;
      cnt_q     <= cnt_d;
      rec_q     <= rec_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_dp_d  = num_dp_q;
    feat_d    = feat_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    sreg_d    = sreg_q;
    nbuf_d    = nbuf_q;
    nvld_d    = nvld_q;
    cnt_d     = cnt_q;
    rec_d     = rec_q;
    done_d    = done_q;
    // a prefetch read issued last cycle returns its data now
    cap_d     = rd_en_q && (state_q == SHIFT);
    if (cap_q) begin
      nbuf_d = rd_data;
      nvld_d = 1'b1;
    end
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_dp_d = num_dp;
          feat_d   = feat;
          done_d   = 1'b0;
          if (num_dp == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = FETCH;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        sreg_d  = rd_data;
        cnt_d   = init;
        rec_d   = '0;
        nvld_d  = 1'b0;
        state_d = SHIFT;
        if (num_dp_q > ADDR_WIDTH'(1)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = ADDR_WIDTH'(1);
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (cnt_q != LAST_IDX) begin
            cnt_d = cnt_q + CW'(1);
          end else if (nvld_q) begin
            sreg_d = nbuf_q;
            cnt_d  = init;
            nvld_d = 1'b0;
            rec_d  = rec_q + ADDR_WIDTH'(1);
            if (rec_p2 < {1'b0, num_dp_q}) begin
              rd_en_d   = 1'b1;
              rd_addr_d = rec_p2[ADDR_WIDTH-1:0];
            end
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign ser_valid = (state_q == SHIFT);
  assign ser       = ser_valid & sreg_q[cnt_q];
  assign busy      = (state_q == FETCH) || (state_q == WAIT)
                   || (state_q == SHIFT);
  assign last      = ser_valid && (cnt_q == LAST_IDX)
                   && (rec_q == num_dp_q - ADDR_WIDTH'(1));
  assign done      = done_q;

endmodule

// File: tb/tb_serial_out.sv
// tb_serial_out: scoreboard bench; expected bits are queued from the
// RAM model when a transfer starts and popped on every accepted bit.
module tb_serial_out;
  localparam int AW = 12;
  localparam int DW = 256;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_dp = '0;
  logic [3:0]    feat = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          ser, ser_valid, last, busy, done;
  logic          ser_ready = 1'b1;
  logic          tog = 1'b0;

  logic [DW-1:0] mem [4];
  exp_t          exp_q[$];
  exp_t          e;
  int            addr_q[$];
  int            acyc_q[$];
  int            checks = 0, errors = 0;
  int            cyc = 0, acc = 0, vcnt = 0, fv = 0, lv = 0;
  logic          hold = 1'b0, hbit = 1'b0, pv = 1'b0;

  serial_out dut (
    .CLK(clk), .RST(rst), .start(start), .num_dp(num_dp),
    .feat(feat), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .ser(ser), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[1:0]];

  always @(posedge clk) begin
    #1;
    ser_ready = tog ? ~ser_ready : 1'b1;
  end

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      addr_q.push_back(int'(rd_addr));
      acyc_q.push_back(cyc);
    end
    if (ser_valid) begin
      if (!pv) fv = cyc;
      lv = cyc;
      vcnt++;
      if (hold) chk("stable", int'(ser), int'(hbit));
      if (ser_ready) begin
        acc++;
        hold = 1'b0;
        if (exp_q.size() == 0) chk("extra_bit", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ser", int'(ser), int'(e.b));
          chk("last", int'(last), int'(e.l));
        end
      end else begin
        hold = 1'b1;
        hbit = ser;
      end
    end else begin
      hold = 1'b0;
    end
    pv = ser_valid;
  end

  task automatic fill();
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < DW/32; w++)
        mem[r][w*32 +: 32] = $urandom;
  endtask

  task automatic push(input int n, input int f);
    exp_t x;
    for (int r = 0; r < n; r++)
      for (int i = 256 - 16*(f+1); i < 256; i++) begin
        x.b = mem[r][i];
        x.l = (r == n-1) && (i == 255);
        exp_q.push_back(x);
      end
  endtask

  task automatic run(input int n, input int f, input bit lat);
    int a0, c0, k;
    push(n, f);
    a0 = addr_q.size();
    c0 = acc;
    @(posedge clk); #1;
    start = 1'b1; num_dp = AW'(n); feat = 4'(f);
    @(posedge clk); #1;
    start = 1'b0;
    num_dp = AW'($urandom); feat = 4'($urandom);
    if (lat) begin
      @(negedge clk);
      chk("lat_rd_en", int'(rd_en), 1);
      chk("lat_addr", int'(rd_addr), 0);
      @(negedge clk);
      chk("lat_novalid", int'(ser_valid), 0);
      @(negedge clk);
      chk("lat_valid", int'(ser_valid), 1);
      repeat (15) @(negedge clk);
      chk("lat_last", int'(last), 1);
      @(negedge clk);
      chk("lat_done", int'(done), 1);
    end
    k = 0;
    while (!done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("timeout", int'(k < 20000), 1);
    @(negedge clk);
    chk("done", int'(done), 1);
    chk("busy", int'(busy), 0);
    chk("valid_end", int'(ser_valid), 0);
    chk("sb_left", exp_q.size(), 0);
    chk("bits", acc - c0, n * 16 * (f+1));
    chk("reads", addr_q.size() - a0, n);
    for (int i = 0; i < n && a0 + i < addr_q.size(); i++)
      chk("rd_addr", addr_q[a0+i], i);
  endtask

  initial begin
    int a0, v0, c0, k;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_ser", int'(ser), 0);
    chk("rst_valid", int'(ser_valid), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_reads", addr_q.size(), 0);
    start = 1'b0;
    rst = 1'b1;

    fill();
    mem[0][255:240] = 16'hA5C3;
    run(1, 0, 1'b1);

    fill();
    a0 = addr_q.size();
    v0 = vcnt;
    run(3, 15, 1'b0);
    chk("valid_cycles", vcnt - v0, 768);
    chk("no_gap", lv - fv + 1, 768);
    if (addr_q.size() > a0 + 1)
      chk("prefetch_early", int'(acyc_q[a0+1] < fv + 256), 1);
    else
      chk("prefetch_seen", addr_q.size() - a0, 3);

    fill();
    tog = 1'b1;
    run(2, 1, 1'b0);
    tog = 1'b0;

    v0 = vcnt;
    run(0, 5, 1'b0);
    chk("zero_valid", vcnt - v0, 0);

    fill();
    push(2, 3);
    c0 = acc;
    @(posedge clk); #1;
    start = 1'b1; num_dp = AW'(2); feat = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (acc - c0 < 5 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    start = 1'b1; num_dp = AW'(1); feat = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start", int'(busy), 1);
    while (acc - c0 < 20 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_wait", int'(k < 500), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    v0 = vcnt;
    a0 = addr_q.size();
    repeat (5) @(negedge clk);
    chk("abort_valid", vcnt - v0, 0);
    chk("abort_reads", addr_q.size() - a0, 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    run(1, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
